// File: rtl/exception_arbiter_pkg.sv
// Shared types, constants and helpers for the commit-stage exception arbiter.
package exception_arbiter_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] DS_OFFSET  = 32'd4;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int IE_BIT = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_HI = 15;
  localparam int IM_LO = 8;
  localparam int IP_HI = 15;
  localparam int IP_LO = 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        has_exc;
    logic [4:0]  exc_code;
    logic        badv_wen;
    logic [31:0] badvaddr;
    logic        in_ds;
    logic        is_eret;
  } slot_t;

  typedef struct packed {
    logic        first;
    logic        second;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        badv_wen;
    logic [31:0] badvaddr;
    logic        clean;
    logic [31:0] redirect_pc;
  } exc_rec_t;

  localparam exc_rec_t REC_RESET = '{
    first: 1'b0, second: 1'b0, epc: 32'd0, code: 5'd0, bd: 1'b0,
    badv_wen: 1'b0, badvaddr: 32'd0, clean: 1'b0, redirect_pc: EXC_VECTOR
  };

  // Delay-slot instructions restart at the branch, one word earlier.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic in_ds);
    return in_ds ? (pc - DS_OFFSET) : pc;
  endfunction

  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return status[IE_BIT] & ~status[EXL_BIT] & (|(status[IM_HI:IM_LO] & cause[IP_HI:IP_LO]));
  endfunction

endpackage

// File: rtl/exception_arbiter_if.sv
// Commit-slot, CP0 and fetch-redirect signal bundle for the exception arbiter.
interface exception_arbiter_if;
  logic        s0_valid, s1_valid;
  logic [31:0] s0_pc, s1_pc;
  logic        s0_has_exc, s1_has_exc;
  logic [4:0]  s0_exc_code, s1_exc_code;
  logic        s0_badv_wen, s1_badv_wen;
  logic [31:0] s0_badvaddr, s1_badvaddr;
  logic        s0_in_ds, s1_in_ds;
  logic        s0_is_eret, s1_is_eret;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        has_exp, exp_first, exp_second;
  logic [31:0] exp_epc;
  logic [4:0]  exp_cause_code;
  logic        exp_is_in_delayslot, wen_badaddress;
  logic [31:0] exp_badaddress;
  logic        exp_clean, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  s0_valid, s1_valid, s0_pc, s1_pc, s0_has_exc, s1_has_exc,
           s0_exc_code, s1_exc_code, s0_badv_wen, s1_badv_wen,
           s0_badvaddr, s1_badvaddr, s0_in_ds, s1_in_ds, s0_is_eret, s1_is_eret,
           cp0_status, cp0_cause, cp0_epc, redirect_ready,
    output has_exp, exp_first, exp_second, exp_epc, exp_cause_code,
           exp_is_in_delayslot, wen_badaddress, exp_badaddress, exp_clean,
           flush, redirect_valid, redirect_pc
  );

  modport master (
    output s0_valid, s1_valid, s0_pc, s1_pc, s0_has_exc, s1_has_exc,
           s0_exc_code, s1_exc_code, s0_badv_wen, s1_badv_wen,
           s0_badvaddr, s1_badvaddr, s0_in_ds, s1_in_ds, s0_is_eret, s1_is_eret,
           cp0_status, cp0_cause, cp0_epc, redirect_ready,
    input  has_exp, exp_first, exp_second, exp_epc, exp_cause_code,
           exp_is_in_delayslot, wen_badaddress, exp_badaddress, exp_clean,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_arbiter_exc_slot_select.sv
// Combinational priority mux: picks the oldest exceptional event of the two
// commit slots and builds the CP0 record for it.
module exc_slot_select
  import exception_arbiter_pkg::*;
(
  input  slot_t       s0_i,
  input  slot_t       s1_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        sel_valid_o,
  output exc_rec_t    sel_rec_o
);

  logic int_pend_s;

  assign int_pend_s = int_pending(cp0_status_i, cp0_cause_i);

  function automatic exc_rec_t exc_record(input slot_t s, input logic is_first);
    exc_rec_t r;
    r.first       = is_first;
    r.second      = ~is_first;
    r.epc         = calc_epc(s.pc, s.in_ds);
    r.code        = s.exc_code;
    r.bd          = s.in_ds;
    r.badv_wen    = s.badv_wen;
    r.badvaddr    = s.badvaddr;
    r.clean       = 1'b0;
    r.redirect_pc = EXC_VECTOR;
    return r;
  endfunction

  function automatic exc_rec_t int_record(input slot_t s, input logic is_first);
    exc_rec_t r;
    r          = exc_record(s, is_first);
    r.code     = EXC_INT;
    r.badv_wen = 1'b0;
    r.badvaddr = 32'd0;
    return r;
  endfunction

  function automatic exc_rec_t eret_record(input slot_t s, input logic is_first, input logic [31:0] epc);
    exc_rec_t r;
    r             = exc_record(s, is_first);
    r.code        = 5'd0;
    r.badv_wen    = 1'b0;
    r.badvaddr    = 32'd0;
    r.clean       = 1'b1;
    r.redirect_pc = epc;
    return r;
  endfunction

  // Priority chain, oldest event first; a slot's exception beats its own ERET.
  always_comb begin
    sel_valid_o = 1'b0;
    sel_rec_o   = REC_RESET;
    if (int_pend_s && s0_i.valid) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = int_record(s0_i, 1'b1);
    end else if (int_pend_s && s1_i.valid) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = int_record(s1_i, 1'b0);
    end else if (s0_i.valid && s0_i.has_exc) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = exc_record(s0_i, 1'b1);
    end else if (s0_i.valid && s0_i.is_eret) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = eret_record(s0_i, 1'b1, cp0_epc_i);
    end else if (s1_i.valid && s1_i.has_exc) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = exc_record(s1_i, 1'b0);
    end else if (s1_i.valid && s1_i.is_eret) begin
      sel_valid_o = 1'b1;
      sel_rec_o   = eret_record(s1_i, 1'b0, cp0_epc_i);
    end else begin
      sel_valid_o = 1'b0;
      sel_rec_o   = REC_RESET;
    end
  end

endmodule

// File: rtl/exception_arbiter.sv
// Commit-stage exception arbiter: registers one exception/ERET record for CP0,
// flushes the pipeline and holds a fetch redirect until it is accepted.
module exception_arbiter
  import exception_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  exception_arbiter_if.slave bus
);

  slot_t    s0_s, s1_s;
  logic     sel_valid_s;
  exc_rec_t sel_rec_s;

  state_e   state_q, state_d;
  exc_rec_t rec_q, rec_d;
  logic     has_exp_q, has_exp_d;
  logic     flush_q, flush_d;
  logic     redir_valid_q, redir_valid_d;

  assign s0_s = '{valid: bus.s0_valid, pc: bus.s0_pc, has_exc: bus.s0_has_exc,
                  exc_code: bus.s0_exc_code, badv_wen: bus.s0_badv_wen,
                  badvaddr: bus.s0_badvaddr, in_ds: bus.s0_in_ds, is_eret: bus.s0_is_eret};
  assign s1_s = '{valid: bus.s1_valid, pc: bus.s1_pc, has_exc: bus.s1_has_exc,
                  exc_code: bus.s1_exc_code, badv_wen: bus.s1_badv_wen,
                  badvaddr: bus.s1_badvaddr, in_ds: bus.s1_in_ds, is_eret: bus.s1_is_eret};

  exc_slot_select u_select (
    .s0_i         (s0_s),
    .s1_i         (s1_s),
    .cp0_status_i (bus.cp0_status),
    .cp0_cause_i  (bus.cp0_cause),
    .cp0_epc_i    (bus.cp0_epc),
    .sel_valid_o  (sel_valid_s),
    .sel_rec_o    (sel_rec_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rec_q         <= REC_RESET;
      has_exp_q     <= 1'b0;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rec_q         <= rec_d;
      has_exp_q     <= has_exp_d;
      flush_q       <= flush_d;
      redir_valid_q <= redir_valid_d;
    end
  end

  // Next state: record is captured only in IDLE, so slot inputs are ignored while redirecting.
  always_comb begin
    state_d       = state_q;
    rec_d         = rec_q;
    has_exp_d     = 1'b0;
    flush_d       = flush_q;
    redir_valid_d = redir_valid_q;
    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          state_d       = REDIRECT;
          rec_d         = sel_rec_s;
          has_exp_d     = 1'b1;
          flush_d       = 1'b1;
          redir_valid_d = 1'b1;
        end else begin
          flush_d       = 1'b0;
          redir_valid_d = 1'b0;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d       = IDLE;
          flush_d       = 1'b0;
          redir_valid_d = 1'b0;
        end else begin
          flush_d       = 1'b1;
          redir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = IDLE;
        flush_d       = 1'b0;
        redir_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.has_exp             = has_exp_q;
  assign bus.exp_first           = rec_q.first;
  assign bus.exp_second          = rec_q.second;
  assign bus.exp_epc             = rec_q.epc;
  assign bus.exp_cause_code      = rec_q.code;
  assign bus.exp_is_in_delayslot = rec_q.bd;
  assign bus.wen_badaddress      = rec_q.badv_wen;
  assign bus.exp_badaddress      = rec_q.badvaddr;
  assign bus.exp_clean           = rec_q.clean;
  assign bus.flush               = flush_q;
  assign bus.redirect_valid      = redir_valid_q;
  assign bus.redirect_pc         = rec_q.redirect_pc;

endmodule

// File: doc/exception_arbiter.md
Name: exception_arbiter

Overview:
- Sits between the dual-issue commit (writeback) stage and the CP0 block.
- Each cycle it picks the oldest exceptional event from the two commit slots: exception, ERET, or pending interrupt.
- It drives a single registered exception record into CP0 and flushes the pipeline.
- It then holds a redirect request to fetch until fetch accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC.
- DS_OFFSET, 32'd4, subtracted from a delay-slot PC to form EPC.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- s0_valid / s1_valid  in  1  commit slot holds a real instruction (slot 0 is older)
- s0_pc / s1_pc  in  32  slot PC
- s0_has_exc / s1_has_exc  in  1  slot raised a synchronous exception
- s0_exc_code / s1_exc_code  in  5  ExcCode
- s0_badv_wen / s1_badv_wen  in  1  slot carries a bad virtual address
- s0_badvaddr / s1_badvaddr  in  32  faulting address
- s0_in_ds / s1_in_ds  in  1  slot is in a branch delay slot
- s0_is_eret / s1_is_eret  in  1  slot is ERET
- cp0_status  in  32  current Status
- cp0_cause  in  32  current Cause
- cp0_epc  in  32  current EPC (ERET target)
- has_exp  out  1  one-cycle exception/ERET pulse to CP0
- exp_first / exp_second  out  1  winning slot, one-hot when has_exp=1
- exp_epc  out  32  EPC value
- exp_cause_code  out  5  ExcCode to CP0
- exp_is_in_delayslot  out  1  Cause.BD
- wen_badaddress  out  1  update BadVAddr
- exp_badaddress  out  32  BadVAddr value
- exp_clean  out  1  event is ERET
- flush  out  1  kill all younger pipeline state
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (async, immediate):
  - all outputs 0, redirect_pc = EXC_VECTOR, state IDLE.
- Interrupt pending (int_pend):
  - int_pend = Status[0] & ~Status[1] & |(Status[15:8] & Cause[15:8]).
  - It attaches to the oldest valid slot: s0 if s0_valid, else s1 if s1_valid, else not taken.
- Selection priority (combinational; only in IDLE), highest first:
  1. int_pend on the attached slot, code 5'd0.
  2. s0_valid & s0_has_exc.
  3. s0_valid & s0_is_eret.
  4. s1_valid & s1_has_exc.
  5. s1_valid & s1_is_eret.
- Whenever slot 0 wins, slot 1 is discarded.
- has_exc on a slot overrides is_eret on the same slot.
- Latency: the event is selected in cycle N. All CP0 outputs are registered and valid in cycle N+1. has_exp is high for exactly one cycle.
- Exception record (non-ERET):
  - exp_epc = in_ds ? pc - DS_OFFSET : pc; arithmetic is 32-bit and wraps modulo 2^32.
  - exp_is_in_delayslot = in_ds.
  - wen_badaddress / exp_badaddress come from the winning slot; for an interrupt they are forced to 0.
  - redirect_pc = EXC_VECTOR.
- ERET record:
  - exp_clean = 1, exp_cause_code = 0, wen_badaddress = 0.
  - redirect_pc = cp0_epc sampled in cycle N.
- FSM states:
  - IDLE: on a selected event, go to REDIRECT and register the record. flush = 1 and redirect_valid = 1 from N+1.
  - REDIRECT: hold flush = 1, redirect_valid = 1 and a stable redirect_pc. Slot inputs are ignored, so no second has_exp is issued. On redirect_ready = 1, return to IDLE next cycle and deassert flush/redirect_valid.
  - redirect_ready asserted in the same cycle redirect_valid rises completes the handshake in one cycle. The earliest next event is accepted 2 cycles after the first.
- Invalid slots are ignored regardless of their other fields; both slots invalid with no event -> stay IDLE.
- Reset asserted mid-REDIRECT -> IDLE immediately; the request is dropped.

Decomposition:
- Shared package holds:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
  - FSM state encoding IDLE/REDIRECT.
  - Status/Cause bit-index constants: IE=0, EXL=1, IM=15:8, IP=15:8.
- One natural sub-module, exc_slot_select: the combinational priority mux producing the record. The registered FSM stays in the top.

Test Plan:
- s0 valid, pc=0x8000_1000, has_exc, code=12, in_ds=0; redirect_ready=1 -> next cycle:
  - has_exp=1, exp_first=1, exp_epc=0x8000_1000, code=12, redirect_pc=0xBFC0_0380.
  - flush falls one cycle later.
- s0 valid, no exc; s1 pc=0x8000_2004, in_ds=1, AdEL, badvaddr=0x1235 ->
  - exp_second=1, exp_epc=0x8000_2000, BD=1, wen_badaddress=1, exp_badaddress=0x1235.
- Both slots have exceptions (s0 Sys, s1 Ov) -> exactly one has_exp pulse, exp_first=1, code=8.
- Status=0x0000_0401, Cause[10]=1, s0 valid with ERET -> interrupt wins: code=0, exp_clean=0.
  - Repeat with Status[1]=1 -> ERET wins: exp_clean=1, redirect_pc=cp0_epc=0x8000_0040.
- redirect_ready held 0 for 5 cycles while new exceptions arrive ->
  - flush/redirect_valid stay 1 and redirect_pc stays stable.
  - has_exp pulses only once; IDLE is reached the cycle after ready.
- Assert reset during REDIRECT -> all outputs 0 and redirect_pc=EXC_VECTOR immediately; no pulse after release.
